// File: rtl/sys_ctrl.sv
`timescale 1ns/1ps
// sys_ctrl: turns UART byte frames into register-file read/write strobes.
// Define SYS_CTRL_TIMEOUT_EN to abandon stalled frames after TIMEOUT_CYCLES.
module sys_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic                  TX_BUSY,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CTRL_BUSY
);

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_EXEC,
        RD_ADDR,
        RD_EXEC,
        RD_WAIT,
        TX_SEND
    } state_t;

    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("sys_ctrl: DATA_WIDTH must be 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
        $error("sys_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    state_t                state_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            tx_data_q;
    logic                  tx_vld_q;
    logic                  busy_q;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_q;
    logic          tmo_wait;
    logic          tmo_evt;

    assign tmo_wait = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                      (state_q == RD_ADDR) || (state_q == RD_WAIT);
    assign tmo_evt  = (state_q == RD_WAIT) ? RdData_Valid : RX_D_VLD;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            tx_vld_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (RX_D_VLD && RX_P_DATA == CMD_WR) begin
                        state_q <= WR_ADDR;
                        busy_q  <= 1'b1;
                    end else if (RX_D_VLD && RX_P_DATA == CMD_RD) begin
                        state_q <= RD_ADDR;
                        busy_q  <= 1'b1;
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state_q <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        wdata_q <= RX_P_DATA;
                        wr_en_q <= 1'b1;
                        state_q <= WR_EXEC;
                    end
                end
                WR_EXEC: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        rd_en_q <= 1'b1;
                        state_q <= RD_EXEC;
                    end
                end
                RD_EXEC: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (RdData_Valid) begin
                        tx_data_q <= RdData;
                        state_q   <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (!TX_BUSY) begin
                        tx_vld_q <= 1'b1;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
`ifdef SYS_CTRL_TIMEOUT_EN
            // Abandon the frame; latched Address/WrData stay as they were.
            if (tmo_wait) begin
                if (tmo_evt) begin
                    tmo_q <= '0;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_q   <= '0;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = addr_q;
    assign WrData    = wdata_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign CTRL_BUSY = busy_q;

endmodule
